// File: rtl/veririsc_pkg.sv
// veririsc_pkg: shared opcode and phase encodings for the VeriRisc CPU blocks
package veririsc_pkg;
    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] PH_INST_ADDR  = 3'd0;
    localparam logic [2:0] PH_INST_FETCH = 3'd1;
    localparam logic [2:0] PH_INST_LOAD  = 3'd2;
    localparam logic [2:0] PH_IDLE       = 3'd3;
    localparam logic [2:0] PH_OP_ADDR    = 3'd4;
    localparam logic [2:0] PH_OP_FETCH   = 3'd5;
    localparam logic [2:0] PH_ALU_OP     = 3'd6;
    localparam logic [2:0] PH_STORE      = 3'd7;

    function automatic logic is_aluop(input logic [2:0] op);
        return op == OP_ADD || op == OP_AND || op == OP_XOR || op == OP_LDA;
    endfunction
endpackage

// File: rtl/cpu_controller.sv
// cpu_controller: 8-phase instruction sequencer decoding phase and opcode into datapath strobes
module cpu_controller
    import veririsc_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                a_is_zero,
    output logic [2:0]          phase,
    output logic                sel,
    output logic                rd,
    output logic                ld_ir,
    output logic                inc_pc,
    output logic                halt,
    output logic                ld_pc,
    output logic                data_e,
    output logic                ld_ac,
    output logic                wr
);
    if (OPCODE_W != 3) begin : g_bad_width
        $error("cpu_controller: only OPCODE_W=3 is supported");
    end

    logic [2:0] phase_q;
    logic       halted_q;
    logic       run;
    logic       alu;
    logic [2:0] op;

    assign op = opcode[2:0];

    // Phase counter; HLT in the operand-address phase parks the sequencer until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q  <= PH_INST_ADDR;
            halted_q <= 1'b0;
        end else if (en && !halted_q) begin
            if (phase_q == PH_OP_ADDR && op == OP_HLT) halted_q <= 1'b1;
            else phase_q <= phase_q + 3'd1;
        end
    end

    // Strobe decode; reset and halt mask every datapath strobe
    always_comb begin
        run    = !rst && !halted_q;
        alu    = is_aluop(op);
        phase  = rst ? PH_INST_ADDR : phase_q;
        sel    = run && phase_q <= PH_IDLE;
        rd     = run && ((phase_q >= PH_INST_FETCH && phase_q <= PH_IDLE) || (phase_q >= PH_OP_FETCH && alu));
        ld_ir  = run && (phase_q == PH_INST_LOAD || phase_q == PH_IDLE);
        inc_pc = run && (phase_q == PH_OP_ADDR || (phase_q == PH_ALU_OP && op == OP_SKZ && a_is_zero));
        halt   = !rst && (halted_q || (phase_q == PH_OP_ADDR && op == OP_HLT));
        ld_pc  = run && phase_q >= PH_ALU_OP && op == OP_JMP;
        data_e = run && phase_q >= PH_ALU_OP && op == OP_STO;
        ld_ac  = run && phase_q == PH_STORE && alu;
        wr     = run && phase_q == PH_STORE && op == OP_STO;
    end

    a_no_rd_wr: assert property (@(posedge clk) !(rd && wr));
endmodule
